// File: rtl/fcvt_i2f_pipe_if.sv
// Handshake bus for the integer-to-binary32 conversion pipe: operand side and result side.
// The conversion unit uses the slave modport; the issuing/writeback side uses master.
interface fcvt_i2f_pipe_if #(
   parameter int TAG_W = 5
) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_int;
   logic             in_unsigned;
   logic [2:0]       in_rm;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [4:0]       out_fflags;
   logic             out_rm_err;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_int, in_unsigned, in_rm, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_fflags, out_rm_err, out_tag
   );

   modport slave (
      input  in_valid, in_int, in_unsigned, in_rm, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_fflags, out_rm_err, out_tag
   );
endinterface

// File: rtl/fcvt_i2f_pipe.sv
// Three-stage FCVT.S.W / FCVT.S.WU pipe (capture, normalize, round/pack) with valid/ready back-pressure.
// Define FCVT_I2F_FLAGS_EN to drive NX in out_fflags[0] and out_rm_err; otherwise both read 0.
module fcvt_i2f_pipe #(
   parameter int TAG_W = 5
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   input  logic           i_flush,
   input  logic [2:0]     i_frm,
   fcvt_i2f_pipe_if.slave s_bus
);
   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   logic             w_rdy1, w_rdy2, w_rdy3;
   logic             r_v1, r_v2, r_v3;

   logic [2:0]       w_rmDyn, w_rmEff;
   logic             w_rmErr;
   logic             w_sign;
   logic [31:0]      w_mag;

   logic             r_sign1;
   logic [31:0]      r_mag1;
   logic [2:0]       r_rm1;
   logic [TAG_W-1:0] r_tag1;

   logic [4:0]       w_lead;
   logic [31:0]      w_norm;

   logic             r_sign2, r_zero2, r_g2, r_r2, r_s2;
   logic [7:0]       r_exp2;
   logic [22:0]      r_man2;
   logic [2:0]       r_rm2;
   logic [TAG_W-1:0] r_tag2;

   logic             w_inc;
   logic [30:0]      w_rounded;
   logic [31:0]      w_result;

   logic [31:0]      r_result3;
   logic [TAG_W-1:0] r_tag3;

`ifdef FCVT_I2F_FLAGS_EN
   logic             r_rmErr1, r_rmErr2, r_rmErr3, r_nx3;
`endif

   // A stage can take new data when empty or when its successor is taking its current data.
   assign w_rdy3 = ~r_v3 | s_bus.out_ready;
   assign w_rdy2 = ~r_v2 | w_rdy3;
   assign w_rdy1 = ~r_v1 | w_rdy2;

   assign s_bus.in_ready   = w_rdy1;
   assign s_bus.out_valid  = r_v3;
   assign s_bus.out_result = r_result3;
   assign s_bus.out_tag    = r_tag3;
`ifdef FCVT_I2F_FLAGS_EN
   assign s_bus.out_fflags = {4'b0000, r_nx3};
   assign s_bus.out_rm_err = r_rmErr3;
`else
   assign s_bus.out_fflags = 5'b00000;
   assign s_bus.out_rm_err = 1'b0;
`endif

   // Stage-1 operand decode: resolve dynamic rm, fold reserved encodings onto truncation.
   always_comb begin
      w_rmDyn = (s_bus.in_rm == RM_DYN) ? i_frm : s_bus.in_rm;
      w_rmErr = (w_rmDyn == 3'b101) | (w_rmDyn == 3'b110) | (w_rmDyn == 3'b111);
      w_rmEff = w_rmErr ? RM_RTZ : w_rmDyn;
      w_sign  = ~s_bus.in_unsigned & s_bus.in_int[31];
      w_mag   = w_sign ? (32'd0 - s_bus.in_int) : s_bus.in_int;
   end

   // Stage-2 normalize: highest set bit wins, then shift it up to bit 31.
   always_comb begin
      w_lead = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (r_mag1[i]) begin
            w_lead = i[4:0];
         end
      end
      w_norm = r_mag1 << (5'd31 - w_lead);
   end

   // Stage-3 rounding; a mantissa carry ripples into the exponent field on its own.
   always_comb begin
      w_inc = 1'b0;
      case (r_rm2)
         RM_RNE:  w_inc = r_g2 & (r_r2 | r_s2 | r_man2[0]);
         RM_RDN:  w_inc = r_sign2 & (r_g2 | r_r2 | r_s2);
         RM_RUP:  w_inc = ~r_sign2 & (r_g2 | r_r2 | r_s2);
         RM_RMM:  w_inc = r_g2;
         default: w_inc = 1'b0;
      endcase
      w_rounded = {r_exp2, r_man2} + {30'd0, w_inc};
      w_result  = r_zero2 ? 32'd0 : {r_sign2, w_rounded};
   end

   // Stage valids: flush beats any accept or advance on the same edge.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else if (i_flush) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else begin
         if (w_rdy1) r_v1 <= s_bus.in_valid;
         if (w_rdy2) r_v2 <= r_v1;
         if (w_rdy3) r_v3 <= r_v2;
      end
   end

   // Stage data only moves on a real transfer, so held results stay stable under stall.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_sign1   <= 1'b0;
         r_mag1    <= 32'd0;
         r_rm1     <= 3'd0;
         r_tag1    <= '0;
         r_sign2   <= 1'b0;
         r_zero2   <= 1'b0;
         r_g2      <= 1'b0;
         r_r2      <= 1'b0;
         r_s2      <= 1'b0;
         r_exp2    <= 8'd0;
         r_man2    <= 23'd0;
         r_rm2     <= 3'd0;
         r_tag2    <= '0;
         r_result3 <= 32'd0;
         r_tag3    <= '0;
`ifdef FCVT_I2F_FLAGS_EN
         r_rmErr1  <= 1'b0;
         r_rmErr2  <= 1'b0;
         r_rmErr3  <= 1'b0;
         r_nx3     <= 1'b0;
`endif
      end else begin
         if (w_rdy1 && s_bus.in_valid) begin
            r_sign1  <= w_sign;
            r_mag1   <= w_mag;
            r_rm1    <= w_rmEff;
            r_tag1   <= s_bus.in_tag;
`ifdef FCVT_I2F_FLAGS_EN
            r_rmErr1 <= w_rmErr;
`endif
         end
         if (w_rdy2 && r_v1) begin
            r_sign2  <= r_sign1;
            r_zero2  <= ~w_norm[31];
            r_exp2   <= 8'd127 + {3'b000, w_lead};
            r_man2   <= w_norm[30:8];
            r_g2     <= w_norm[7];
            r_r2     <= w_norm[6];
            r_s2     <= |w_norm[5:0];
            r_rm2    <= r_rm1;
            r_tag2   <= r_tag1;
`ifdef FCVT_I2F_FLAGS_EN
            r_rmErr2 <= r_rmErr1;
`endif
         end
         if (w_rdy3 && r_v2) begin
            r_result3 <= w_result;
            r_tag3    <= r_tag2;
`ifdef FCVT_I2F_FLAGS_EN
            r_nx3     <= r_g2 | r_r2 | r_s2;
            r_rmErr3  <= r_rmErr2;
`endif
         end
      end
   end
endmodule
